// File: rtl/vx_mem_rsp_reorder_pkg.sv
// ---------------------------------------------------------------------------
// vx_mem_rsp_reorder_pkg : shared types and widths for the memory response reorder buffer
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package vx_mem_rsp_reorder_pkg;

  localparam int VX_MEM_ADDR_WIDTH = 26;
  localparam int VX_MEM_DATA_WIDTH = 512;
  localparam int VX_MEM_TAG_WIDTH  = 8;
  localparam int VX_MEM_NUM_IDS    = 16;

  typedef struct packed {
    logic [VX_MEM_TAG_WIDTH-1:0]  tag;
    logic [VX_MEM_DATA_WIDTH-1:0] data;
  } rob_entry_t;

  // Slot ID width; never narrower than one bit so that index vectors stay legal.
  function automatic int rob_id_width(input int num_ids);
    return (num_ids > 1) ? $clog2(num_ids) : 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/vx_mem_rsp_reorder_rob_ram.sv
// ---------------------------------------------------------------------------
// vx_rob_ram : per-slot tag and data storage, two independent write ports, async read
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module vx_rob_ram
  import vx_mem_rsp_reorder_pkg::*;
#(
  parameter int NUM_IDS    = VX_MEM_NUM_IDS,
  parameter int ID_WIDTH   = rob_id_width(NUM_IDS),
  parameter int TAG_WIDTH  = VX_MEM_TAG_WIDTH,
  parameter int DATA_WIDTH = VX_MEM_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  tag_we,
  input  logic [ID_WIDTH-1:0]   tag_waddr,
  input  logic [TAG_WIDTH-1:0]  tag_wdata,
  input  logic                  data_we,
  input  logic [ID_WIDTH-1:0]   data_waddr,
  input  logic [DATA_WIDTH-1:0] data_wdata,
  input  logic [ID_WIDTH-1:0]   raddr,
  output logic [TAG_WIDTH-1:0]  rd_tag,
  output logic [DATA_WIDTH-1:0] rd_data
);

  logic [TAG_WIDTH-1:0]  tag_mem_q  [NUM_IDS];
  logic [DATA_WIDTH-1:0] data_mem_q [NUM_IDS];

  // Tags are captured at allocation, data at response time; the two never target
  // the same slot in one cycle, so the ports are kept fully independent.
  always_ff @(posedge clk) begin
    if (tag_we) begin
      tag_mem_q[tag_waddr] <= tag_wdata;
    end
    if (data_we) begin
      data_mem_q[data_waddr] <= data_wdata;
    end
  end

  assign rd_tag  = tag_mem_q[raddr];
  assign rd_data = data_mem_q[raddr];

endmodule

`default_nettype wire

// File: rtl/vx_mem_rsp_reorder.sv
// ---------------------------------------------------------------------------
// vx_mem_rsp_reorder : assigns slot IDs to reads and returns responses in request order
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module vx_mem_rsp_reorder
  import vx_mem_rsp_reorder_pkg::*;
#(
  parameter int ADDR_WIDTH = VX_MEM_ADDR_WIDTH,
  parameter int DATA_WIDTH = VX_MEM_DATA_WIDTH,
  parameter int TAG_WIDTH  = VX_MEM_TAG_WIDTH,
  parameter int NUM_IDS    = VX_MEM_NUM_IDS,
  parameter int ID_WIDTH   = rob_id_width(NUM_IDS)
) (
  input  logic                    clk,
  input  logic                    reset,

  input  logic                    core_req_valid,
  input  logic                    core_req_rw,
  input  logic [DATA_WIDTH/8-1:0] core_req_byteen,
  input  logic [ADDR_WIDTH-1:0]   core_req_addr,
  input  logic [DATA_WIDTH-1:0]   core_req_data,
  input  logic [TAG_WIDTH-1:0]    core_req_tag,
  output logic                    core_req_ready,

  output logic                    core_rsp_valid,
  output logic [DATA_WIDTH-1:0]   core_rsp_data,
  output logic [TAG_WIDTH-1:0]    core_rsp_tag,
  input  logic                    core_rsp_ready,

  output logic                    mem_req_valid,
  output logic                    mem_req_rw,
  output logic [DATA_WIDTH/8-1:0] mem_req_byteen,
  output logic [ADDR_WIDTH-1:0]   mem_req_addr,
  output logic [DATA_WIDTH-1:0]   mem_req_data,
  output logic [ID_WIDTH-1:0]     mem_req_id,
  input  logic                    mem_req_ready,

  input  logic                    mem_rsp_valid,
  input  logic [DATA_WIDTH-1:0]   mem_rsp_data,
  input  logic [ID_WIDTH-1:0]     mem_rsp_id,
  output logic                    mem_rsp_ready,

  output logic [ID_WIDTH:0]       pending,
  output logic                    busy
);

  localparam int PTR_W = ID_WIDTH + 1;

  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [NUM_IDS-1:0] vld_q, vld_d;

  logic [PTR_W-1:0]    ptr_diff;
  logic                full;
  logic                req_ok;
  logic                read_fire;
  logic                retire;
  logic [ID_WIDTH-1:0] alloc_id;
  logic [ID_WIDTH-1:0] head_id;
  logic [ID_WIDTH-1:0] rsp_offset;
  logic                in_flight;
  logic                rsp_fire;
  logic                rsp_accept;
  logic                rsp_drop;

  assign alloc_id = wr_ptr_q[ID_WIDTH-1:0];
  assign head_id  = rd_ptr_q[ID_WIDTH-1:0];
  assign ptr_diff = wr_ptr_q - rd_ptr_q;
  assign full     = (ptr_diff == PTR_W'(NUM_IDS));

  // Writes never consume a slot, so only reads are throttled by occupancy.
  assign req_ok         = core_req_rw | ~full;
  assign mem_req_valid  = reset & core_req_valid & req_ok;
  assign core_req_ready = reset & mem_req_ready & req_ok;
  assign read_fire      = core_req_valid & core_req_ready & ~core_req_rw;

  assign mem_req_rw     = core_req_rw;
  assign mem_req_byteen = core_req_byteen;
  assign mem_req_addr   = core_req_addr;
  assign mem_req_data   = core_req_data;
  assign mem_req_id     = core_req_rw ? '0 : alloc_id;

  // A response is legal only for a slot between head and tail that is still empty.
  assign rsp_offset = mem_rsp_id - head_id;
  assign in_flight  = ({1'b0, rsp_offset} < ptr_diff);
  assign rsp_fire   = reset & mem_rsp_valid;
  assign rsp_accept = rsp_fire & in_flight & ~vld_q[mem_rsp_id];
  assign rsp_drop   = rsp_fire & ~rsp_accept;

  assign mem_rsp_ready  = reset;
  assign core_rsp_valid = reset & vld_q[head_id];
  assign retire         = core_rsp_valid & core_rsp_ready;

  assign pending = reset ? ptr_diff : '0;
  assign busy    = (pending != '0);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    vld_d    = vld_q;
    if (read_fire) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
    if (retire) begin
      rd_ptr_d       = rd_ptr_q + 1'b1;
      vld_d[head_id] = 1'b0;
    end
    // The head slot is already valid when it retires, so an accepted response
    // can never collide with the bit being cleared above.
    if (rsp_accept) begin
      vld_d[mem_rsp_id] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      vld_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      vld_q    <= vld_d;
    end
  end

  vx_rob_ram #(
    .NUM_IDS    (NUM_IDS),
    .ID_WIDTH   (ID_WIDTH),
    .TAG_WIDTH  (TAG_WIDTH),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_rob_ram (
    .clk        (clk),
    .tag_we     (read_fire),
    .tag_waddr  (alloc_id),
    .tag_wdata  (core_req_tag),
    .data_we    (rsp_accept),
    .data_waddr (mem_rsp_id),
    .data_wdata (mem_rsp_data),
    .raddr      (head_id),
    .rd_tag     (core_rsp_tag),
    .rd_data    (core_rsp_data)
  );

`ifndef SYNTHESIS
  always @(posedge clk) begin
    if (reset) begin
      assert (!rsp_drop)
        else $warning("vx_mem_rsp_reorder: dropped response for id %0d", mem_rsp_id);
    end
  end
`endif

endmodule

`default_nettype wire

// File: tb/tb_vx_mem_rsp_reorder.sv
// ---------------------------------------------------------------------------
// tb_vx_mem_rsp_reorder : directed self-checking bench for the response reorder buffer
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_vx_mem_rsp_reorder;

  localparam int AW = 26;
  localparam int DW = 512;
  localparam int TW = 8;
  localparam int NI = 16;
  localparam int IW = 4;

  logic            clk = 1'b0;
  logic            reset = 1'b0;
  logic            core_req_valid = 1'b0;
  logic            core_req_rw = 1'b0;
  logic [DW/8-1:0] core_req_byteen = '0;
  logic [AW-1:0]   core_req_addr = '0;
  logic [DW-1:0]   core_req_data = '0;
  logic [TW-1:0]   core_req_tag = '0;
  logic            core_req_ready;
  logic            core_rsp_valid;
  logic [DW-1:0]   core_rsp_data;
  logic [TW-1:0]   core_rsp_tag;
  logic            core_rsp_ready = 1'b0;
  logic            mem_req_valid;
  logic            mem_req_rw;
  logic [DW/8-1:0] mem_req_byteen;
  logic [AW-1:0]   mem_req_addr;
  logic [DW-1:0]   mem_req_data;
  logic [IW-1:0]   mem_req_id;
  logic            mem_req_ready = 1'b1;
  logic            mem_rsp_valid = 1'b0;
  logic [DW-1:0]   mem_rsp_data = '0;
  logic [IW-1:0]   mem_rsp_id = '0;
  logic            mem_rsp_ready;
  logic [IW:0]     pending;
  logic            busy;

  int n_cmp = 0;
  int n_bad = 0;
  int n_alloc = 0;
  int n_ret = 0;

  always #5 clk = ~clk;

  vx_mem_rsp_reorder #(
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (DW),
    .TAG_WIDTH  (TW),
    .NUM_IDS    (NI),
    .ID_WIDTH   (IW)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .core_req_valid  (core_req_valid),
    .core_req_rw     (core_req_rw),
    .core_req_byteen (core_req_byteen),
    .core_req_addr   (core_req_addr),
    .core_req_data   (core_req_data),
    .core_req_tag    (core_req_tag),
    .core_req_ready  (core_req_ready),
    .core_rsp_valid  (core_rsp_valid),
    .core_rsp_data   (core_rsp_data),
    .core_rsp_tag    (core_rsp_tag),
    .core_rsp_ready  (core_rsp_ready),
    .mem_req_valid   (mem_req_valid),
    .mem_req_rw      (mem_req_rw),
    .mem_req_byteen  (mem_req_byteen),
    .mem_req_addr    (mem_req_addr),
    .mem_req_data    (mem_req_data),
    .mem_req_id      (mem_req_id),
    .mem_req_ready   (mem_req_ready),
    .mem_rsp_valid   (mem_rsp_valid),
    .mem_rsp_data    (mem_rsp_data),
    .mem_rsp_id      (mem_rsp_id),
    .mem_rsp_ready   (mem_rsp_ready),
    .pending         (pending),
    .busy            (busy)
  );

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] mk_data(input int v);
    logic [DW-1:0] d;
    for (int i = 0; i < DW/32; i++) begin
      d[i*32 +: 32] = 32'(v) * 32'h0101_0101 + 32'(i);
    end
    return d;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_pend();
    check("pending", DW'(pending), DW'(n_alloc - n_ret));
    check("busy", DW'(busy), DW'(n_alloc != n_ret));
  endtask

  task automatic rd_req(input int tag);
    core_req_valid = 1'b1;
    core_req_rw    = 1'b0;
    core_req_tag   = TW'(tag);
    core_req_addr  = AW'(n_alloc);
    #1;
    check("rd_ready", DW'(core_req_ready), DW'(1));
    check("rd_id", DW'(mem_req_id), DW'(n_alloc % NI));
    step();
    core_req_valid = 1'b0;
    n_alloc++;
  endtask

  task automatic mem_rsp(input int id, input int v);
    mem_rsp_valid = 1'b1;
    mem_rsp_id    = IW'(id);
    mem_rsp_data  = mk_data(v);
    step();
    mem_rsp_valid = 1'b0;
  endtask

  task automatic pop(input int tag);
    core_rsp_ready = 1'b1;
    #1;
    check("rsp_valid", DW'(core_rsp_valid), DW'(1));
    check("rsp_tag", DW'(core_rsp_tag), DW'(tag));
    check("rsp_data", core_rsp_data, mk_data(tag));
    step();
    core_rsp_ready = 1'b0;
    n_ret++;
  endtask

  task automatic batch(input int n, input int base);
    int start;
    start = n_alloc;
    for (int j = 0; j < n; j++) rd_req(base + j);
    for (int j = n - 1; j >= 0; j--) mem_rsp((start + j) % NI, base + j);
    for (int j = 0; j < n; j++) pop(base + j);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int head;

    // reset state with live request inputs
    core_req_valid = 1'b1;
    #12;
    check("rst_req_ready", DW'(core_req_ready), DW'(0));
    check("rst_mem_valid", DW'(mem_req_valid), DW'(0));
    check("rst_rsp_valid", DW'(core_rsp_valid), DW'(0));
    check("rst_mrsp_ready", DW'(mem_rsp_ready), DW'(0));
    chk_pend();
    core_req_valid = 1'b0;
    step();
    reset = 1'b1;
    step();
    check("mrsp_ready", DW'(mem_rsp_ready), DW'(1));

    // memory backpressure blocks acceptance
    core_req_valid = 1'b1;
    mem_req_ready  = 1'b0;
    #1;
    check("bp_ready", DW'(core_req_ready), DW'(0));
    mem_req_ready  = 1'b1;
    core_req_valid = 1'b0;
    step();

    // 1: out-of-order responses returned in order
    rd_req('h11);
    rd_req('h22);
    rd_req('h33);
    chk_pend();
    mem_rsp(2, 'h33);
    check("t1_not_head", DW'(core_rsp_valid), DW'(0));
    mem_rsp(0, 'h11);
    check("t1_head_lat", DW'(core_rsp_valid), DW'(1));
    mem_rsp(1, 'h22);
    pop('h11);
    pop('h22);
    pop('h33);
    chk_pend();

    // 2: fill all 16 slots
    for (int i = 0; i < NI; i++) rd_req('h40 + i);
    chk_pend();
    core_req_valid = 1'b1;
    core_req_rw    = 1'b0;
    #1;
    check("full_rd_ready", DW'(core_req_ready), DW'(0));
    check("full_rd_mvalid", DW'(mem_req_valid), DW'(0));
    core_req_rw     = 1'b1;
    core_req_addr   = 26'h155_AAAA;
    core_req_byteen = {(DW/16){2'b10}};
    core_req_data   = mk_data('h5A);
    #1;
    check("wr_ready", DW'(core_req_ready), DW'(1));
    check("wr_mvalid", DW'(mem_req_valid), DW'(1));
    check("wr_id", DW'(mem_req_id), DW'(0));
    check("wr_rw", DW'(mem_req_rw), DW'(1));
    check("wr_addr", DW'(mem_req_addr), DW'(26'h155_AAAA));
    check("wr_byteen", DW'(mem_req_byteen), DW'({(DW/16){2'b10}}));
    check("wr_data", mem_req_data, mk_data('h5A));
    step();
    core_req_valid = 1'b0;
    core_req_rw    = 1'b0;
    chk_pend();

    // 3: head held while core is not ready
    mem_rsp(3, 'h40);
    for (int k = 0; k < 5; k++) begin
      check("hold_valid", DW'(core_rsp_valid), DW'(1));
      check("hold_tag", DW'(core_rsp_tag), DW'('h40));
      check("hold_data", core_rsp_data, mk_data('h40));
      check("hold_pending", DW'(pending), DW'(16));
      step();
    end
    pop('h40);
    chk_pend();

    // 4: allocation and retirement in the same cycle
    mem_rsp(4, 'h41);
    core_rsp_ready = 1'b1;
    core_req_valid = 1'b1;
    core_req_rw    = 1'b0;
    core_req_tag   = 8'h80;
    #1;
    check("same_rsp_tag", DW'(core_rsp_tag), DW'('h41));
    check("same_req_ready", DW'(core_req_ready), DW'(1));
    check("same_req_id", DW'(mem_req_id), DW'(3));
    step();
    core_rsp_ready = 1'b0;
    core_req_valid = 1'b0;
    n_alloc++;
    n_ret++;
    chk_pend();
    mem_rsp(3, 'h80);
    for (int i = NI - 1; i >= 2; i--) mem_rsp((3 + i) % NI, 'h40 + i);
    for (int i = 2; i < NI; i++) pop('h40 + i);
    pop('h80);
    chk_pend();

    // wrap the pointers past 32 allocations
    batch(8, 'hC0);
    batch(7, 'hD0);
    chk_pend();

    // 6: duplicate and stray responses are dropped
    rd_req('hA0);
    rd_req('hA1);
    rd_req('hA2);
    mem_rsp_valid = 1'b1;
    mem_rsp_id    = 4'd3;
    mem_rsp_data  = mk_data('hA0);
    #1;
    check("first_drop", DW'(dut.rsp_drop), DW'(0));
    step();
    mem_rsp_data = mk_data('hEE);
    #1;
    check("dup_drop", DW'(dut.rsp_drop), DW'(1));
    step();
    mem_rsp_id = 4'd9;
    #1;
    check("stray_drop", DW'(dut.rsp_drop), DW'(1));
    step();
    mem_rsp_valid = 1'b0;
    check("dup_data_kept", core_rsp_data, mk_data('hA0));
    mem_rsp(5, 'hA2);
    mem_rsp(4, 'hA1);
    pop('hA0);
    pop('hA1);
    pop('hA2);
    chk_pend();

    // 5: reset with 7 reads pending
    head = n_alloc % NI;
    for (int i = 0; i < 7; i++) rd_req('h60 + i);
    chk_pend();
    mem_rsp(head, 'h60);
    check("pre_rst_valid", DW'(core_rsp_valid), DW'(1));
    reset = 1'b0;
    #1;
    check("mid_rst_pending", DW'(pending), DW'(0));
    check("mid_rst_busy", DW'(busy), DW'(0));
    check("mid_rst_rsp_valid", DW'(core_rsp_valid), DW'(0));
    check("mid_rst_mrsp_ready", DW'(mem_rsp_ready), DW'(0));
    check("mid_rst_req_ready", DW'(core_req_ready), DW'(0));
    step();
    reset   = 1'b1;
    n_alloc = 0;
    n_ret   = 0;
    step();
    rd_req('h77);
    mem_rsp(0, 'h77);
    pop('h77);
    chk_pend();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
